logic_wb_queue: RTL and testbench
=================================

Name: logic_wb_queue

Overview:
- Writeback stage directly downstream of the LOGIC execution unit.
- Captures the destination register tag when an operation is issued to LOGIC.
- On LOGIC's `done` pulse, pairs that tag with `res` and queues the pair in a small FIFO.
- Drains entries to the register-file write port over a valid/ready handshake, and back-pressures issue when no result slot can be guaranteed.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, >= 2.
- AW, 2, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of queue and pending tag (pipeline flush).
- issue_start  input  1  issue stage launches a LOGIC op this cycle; same signal drives LOGIC `start`.
- issue_rd  input  5  destination register index of the op being issued.
- issue_ready  output  1  issue permitted this cycle.
- lu_done  input  1  LOGIC `done` pulse.
- lu_res  input  32  LOGIC `res`; valid only while lu_done=1.
- wb_valid  output  1  head entry available for writeback.
- wb_rd  output  5  head entry destination register.
- wb_data  output  32  head entry result.
- wb_ready  input  1  register file accepts the head entry this cycle.
- count  output  AW+1  number of occupied FIFO entries.
- orphan_err  output  1  sticky; a lu_done arrived with no pending tag.

Behaviour:

Reset (rst=0, asynchronous):
- count=0, pending valid=0, pending rd=0, read/write pointers=0.
- wb_valid=0, wb_rd=0, wb_data=0, orphan_err=0.
- issue_ready=1 immediately after release.
- FIFO storage is not reset.
- Reset asserted mid-operation discards the pending tag and all entries. A later lu_done from the old op then sets orphan_err.

Issue:
- issue_ready = !pend_valid && (count < DEPTH), combinational from registered state only.
- issue_start && issue_ready: pend_valid<=1, pend_rd<=issue_rd.
- issue_start while issue_ready=0 is ignored (issue stage bug; no state change).
- One op in flight at a time. An issue in the same cycle as lu_done is not accepted, because pend_valid is still 1.
- Space is reserved at issue. count cannot rise before done, so the push always fits.

Completion:
- lu_done && pend_valid && pend_rd!=0: write {pend_rd, lu_res} at wr_ptr, wr_ptr+1 mod DEPTH, pend_valid<=0.
- lu_done && pend_valid && pend_rd==0: result discarded (x0), no push, pend_valid<=0.
- lu_done && !pend_valid: no push, orphan_err<=1. orphan_err is cleared only by rst.

Drain:
- First-word-fall-through.
- wb_valid = (count!=0).
- wb_rd/wb_data = entry at rd_ptr when wb_valid=1, otherwise 0.
- Pop when wb_valid && wb_ready: rd_ptr+1 mod DEPTH.
- While wb_valid=1 and wb_ready=0, wb_rd/wb_data hold stable.

Count and latency:
- count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Full (count==DEPTH): issue_ready=0; no push can occur.
- Empty: wb_ready is ignored.
- Latency: lu_done in cycle N -> wb_valid=1 in cycle N+1 when the queue was empty.
- Pointers wrap naturally at DEPTH. Push into a slot in the same cycle as a pop of a different slot is legal.

Flush (synchronous, highest priority over push/pop/issue in that cycle):
- count=0, pointers=0, pend_valid=0.
- orphan_err is not affected.

Test Plan:
1. Reset, then issue rd=5. LOGIC completes with lu_res=32'h5555_5555 (op1=aaaa_aaaa XOR ffff_ffff), wb_ready=1 -> one cycle after lu_done: wb_valid=1, wb_rd=5, wb_data=32'h5555_5555. Next cycle count=0 and issue_ready=1.
2. wb_ready held 0; four ops with rd=1..4, res=32'h11,22,33,44 -> count reaches 4, issue_ready=0. Raise wb_ready -> entries appear in order 1/11, 2/22, 3/33, 4/44, one per cycle; wrap verified by four more ops rd=6..9.
3. Queue holds 1 entry, wb_ready=1, lu_done with pending rd=7 in the same cycle -> count stays 1 and the head becomes rd=7.
4. Issue rd=0, lu_done res=32'hdead_beef -> no push, wb_valid stays 0, issue_ready returns to 1.
5. lu_done pulse with no prior issue -> orphan_err=1 and stays set through a flush; only rst clears it.
6. Two entries queued plus a pending op; assert rst low asynchronously between clock edges -> wb_valid, count and issue_ready reach their reset values (0, 0, 1 after release) without a clock edge. Separately, flush with entries queued -> count=0 on the next edge.

Source files
------------

// File: rtl/logic_wb_queue.sv
// Writeback queue behind the LOGIC unit: tags each issued op with its destination
// register, pairs the tag with the result on done, and drains FWFT to the register file.
module logic_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          issue_start,
  input  logic [4:0]    issue_rd,
  output logic          issue_ready,
  input  logic          lu_done,
  input  logic [31:0]   lu_res,
  output logic          wb_valid,
  output logic [4:0]    wb_rd,
  output logic [31:0]   wb_data,
  input  logic          wb_ready,
  output logic [AW:0]   count,
  output logic          orphan_err
);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            pend_valid;
  logic [4:0]      pend_rd;
  logic            push;
  logic            pop;

  // Space was reserved at issue time, so a push never needs a full check.
  assign push        = lu_done && pend_valid && (pend_rd != 5'd0);
  assign pop         = wb_valid && wb_ready;
  assign issue_ready = !pend_valid && (count < FULL);
  assign wb_valid    = (count != '0);

  always_comb begin
    wb_rd   = '0;
    wb_data = '0;
    if (wb_valid) begin
      wb_rd   = mem[rd_ptr].rd;
      wb_data = mem[rd_ptr].data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pend_valid <= 1'b0;
      pend_rd    <= '0;
      orphan_err <= 1'b0;
    end else begin
      if (lu_done && !pend_valid) orphan_err <= 1'b1;

      if (flush) begin
        count      <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        pend_valid <= 1'b0;
      end else begin
        if (lu_done && pend_valid) begin
          pend_valid <= 1'b0;
        end else if (issue_start && issue_ready) begin
          pend_valid <= 1'b1;
          pend_rd    <= issue_rd;
        end

        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);

        case ({push, pop})
          2'b10:   count <= count + (AW + 1)'(1);
          2'b01:   count <= count - (AW + 1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // NOTE: storage has no reset; count and pointers alone decide what is valid,
  // and a resettable array would cost a reset fan-out for no functional gain.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= '{rd: pend_rd, data: lu_res};
  end

endmodule

// File: tb/tb_logic_wb_queue.sv
// Scoreboard bench for logic_wb_queue: expected writebacks are queued when a
// completion is driven and compared in order whenever the DUT hands one off.
module tb_logic_wb_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          issue_start;
  logic [4:0]    issue_rd;
  logic          issue_ready;
  logic          lu_done;
  logic [31:0]   lu_res;
  logic          wb_valid;
  logic [4:0]    wb_rd;
  logic [31:0]   wb_data;
  logic          wb_ready;
  logic [AW:0]   count;
  logic          orphan_err;

  logic_wb_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .issue_start (issue_start),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .lu_done     (lu_done),
    .lu_res      (lu_res),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .wb_ready    (wb_ready),
    .count       (count),
    .orphan_err  (orphan_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [36:0] sb [$];
  logic        m_pend_valid = 1'b0;
  logic [4:0]  m_pend_rd    = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_op(input logic [4:0] rd);
    issue_start = 1'b1;
    issue_rd    = rd;
    if (!m_pend_valid && (sb.size() < DEPTH)) begin
      m_pend_valid = 1'b1;
      m_pend_rd    = rd;
    end
    tick();
    issue_start = 1'b0;
  endtask

  task automatic done_op(input logic [31:0] res);
    logic pushes;
    pushes  = m_pend_valid && (m_pend_rd != 5'd0);
    lu_done = 1'b1;
    lu_res  = res;
    tick();
    lu_done = 1'b0;
    if (pushes) sb.push_back({m_pend_rd, res});
    m_pend_valid = 1'b0;
  endtask

  // Monitor: a handshake seen at the negedge completes on the next posedge.
  always @(negedge clk) begin
    logic [36:0] exp_e;
    if (rst) begin
      check("mon_valid", 64'(wb_valid), 64'(sb.size() != 0));
      if (wb_valid && wb_ready) begin
        if (sb.size() == 0) begin
          check("mon_sb_empty", 64'(1), 64'(0));
        end else begin
          exp_e = sb.pop_front();
          check("mon_rd",   64'(wb_rd),   64'(exp_e[36:32]));
          check("mon_data", 64'(wb_data), 64'(exp_e[31:0]));
        end
      end
    end
  end

  initial begin
    rst = 1'b0; flush = 1'b0; issue_start = 1'b0; issue_rd = '0;
    lu_done = 1'b0; lu_res = '0; wb_ready = 1'b1;
    #12;
    check("rst_count",  64'(count), 64'(0));
    check("rst_valid",  64'(wb_valid), 64'(0));
    check("rst_rd",     64'(wb_rd), 64'(0));
    check("rst_data",   64'(wb_data), 64'(0));
    check("rst_orphan", 64'(orphan_err), 64'(0));
    rst = 1'b1;
    tick();
    check("rst_ready",  64'(issue_ready), 64'(1));

    // 1: single op, immediate drain
    issue_op(5'd5);
    check("t1_busy", 64'(issue_ready), 64'(0));
    done_op(32'haaaa_aaaa ^ 32'hffff_ffff);
    check("t1_valid", 64'(wb_valid), 64'(1));
    check("t1_rd",    64'(wb_rd), 64'(5));
    check("t1_data",  64'(wb_data), 64'h5555_5555);
    tick();
    check("t1_count", 64'(count), 64'(0));
    check("t1_ready", 64'(issue_ready), 64'(1));

    // 2: fill, stall, drain in order, then wrap
    wb_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      issue_op(5'(i));
      done_op(32'(i * 17));
    end
    check("t2_full",     64'(count), 64'(4));
    check("t2_noissue",  64'(issue_ready), 64'(0));
    issue_op(5'd9);
    check("t2_ignored",  64'(count), 64'(4));
    check("t2_stable_rd",   64'(wb_rd), 64'(1));
    check("t2_stable_data", 64'(wb_data), 64'h11);
    wb_ready = 1'b1;
    repeat (4) tick();
    check("t2_drained", 64'(count), 64'(0));
    wb_ready = 1'b0;
    for (int i = 6; i <= 9; i++) begin
      issue_op(5'(i));
      done_op(32'(i * 17));
    end
    check("t2_wrap_full", 64'(count), 64'(4));
    wb_ready = 1'b1;
    repeat (4) tick();
    check("t2_wrap_empty", 64'(count), 64'(0));

    // 3: simultaneous push and pop
    wb_ready = 1'b0;
    issue_op(5'd10);
    done_op(32'h0a0a);
    issue_op(5'd7);
    wb_ready = 1'b1;
    done_op(32'h7777);
    check("t3_count", 64'(count), 64'(1));
    check("t3_head",  64'(wb_rd), 64'(7));
    tick();
    check("t3_empty", 64'(count), 64'(0));

    // 4: x0 destination is discarded
    issue_op(5'd0);
    done_op(32'hdead_beef);
    check("t4_valid", 64'(wb_valid), 64'(0));
    check("t4_ready", 64'(issue_ready), 64'(1));

    // 5: orphan done is sticky across flush
    done_op(32'h1234);
    check("t5_orphan", 64'(orphan_err), 64'(1));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t5_sticky", 64'(orphan_err), 64'(1));

    // 6: async reset mid-operation, then flush
    wb_ready = 1'b0;
    issue_op(5'd3);  done_op(32'h33);
    issue_op(5'd4);  done_op(32'h44);
    issue_op(5'd12);
    check("t6_two", 64'(count), 64'(2));
    #2;
    rst = 1'b0;
    sb.delete();
    m_pend_valid = 1'b0;
    #1;
    check("t6_rst_valid",  64'(wb_valid), 64'(0));
    check("t6_rst_count",  64'(count), 64'(0));
    check("t6_rst_orphan", 64'(orphan_err), 64'(0));
    tick();
    rst = 1'b1;
    tick();
    check("t6_rst_ready", 64'(issue_ready), 64'(1));
    done_op(32'hc0c0);
    check("t6_late_orphan", 64'(orphan_err), 64'(1));
    issue_op(5'd3);  done_op(32'h33);
    issue_op(5'd4);  done_op(32'h44);
    check("t6_refill", 64'(count), 64'(2));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sb.delete();
    check("t6_flush_count", 64'(count), 64'(0));
    check("t6_flush_valid", 64'(wb_valid), 64'(0));
    tick();

    check("sb_drained", 64'(sb.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
